prog_mem: RTL and testbench
===========================

# prog_mem

Parametrised, synchronous program memory for the DAPA2014 core, holding the instruction words fetched by the control unit. It has two ports: a registered-read fetch port for the processor and a handshaked load port so a host or bench can write a program at run time. Optionally, it self-initialises from a built-in boot image after reset. It sits between the instruction register and the external loader.

## Interface
Parameters:
- DATA_W, 16, instruction word width
- ADDR_W, 8, address width
- DEPTH, 2**ADDR_W, number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_en  in  1  fetch request
- addr  in  ADDR_W  fetch address
- data  out  DATA_W  registered fetch data
- data_valid  out  1  one-cycle pulse, data updated
- busy  out  1  high in INIT or LOAD; fetches ignored
- ld_start  in  1  begin load (sampled in IDLE only)
- ld_base  in  ADDR_W  first load address, captured with ld_start
- ld_valid  in  1  ld_word valid
- ld_word  in  DATA_W  word to write
- ld_last  in  1  qualifies final word, with ld_valid
- ld_ready  out  1  high in LOAD
- ld_done  out  1  one-cycle pulse after last word written
- ld_count  out  ADDR_W+1  words accepted in current/last load
- ld_overflow  out  1  sticky: load wrote more than DEPTH words

## Operation
- Storage: DEPTH x DATA_W array. Address arithmetic is modulo DEPTH; an addr ≥ DEPTH reads 0.
- FSM states are INIT (only with the macro), IDLE, and LOAD.
- Reset puts the FSM in INIT if the macro is defined, otherwise in IDLE.
- Reset values: data=0, data_valid=0, ld_done=0, ld_count=0, ld_overflow=0, ld_ready=0. busy=1 if the macro is defined, otherwise 0.
- IDLE behaviour:
  - rd_en=1 → data ← mem[addr] at the next edge, with data_valid=1 for that cycle.
  - rd_en=0 → data holds its value and data_valid=0.
  - ld_start=1 → enter LOAD: capture ld_base, clear ld_count and ld_overflow.
  - rd_en and ld_start together: the read is still served, then LOAD is entered.
  - ld_valid in IDLE is ignored.
- LOAD behaviour:
  - ld_ready=1 and busy=1.
  - Each cycle with ld_valid=1 writes ld_word to (ld_base + ld_count) mod DEPTH and increments ld_count.
  - When ld_count reaches DEPTH, the next accepted word sets ld_overflow. Writing continues with wrap, and ld_count saturates at 2**ADDR_W.
  - ld_valid & ld_last → that word is written, the FSM returns to IDLE, and ld_done pulses in the next cycle.
  - rd_en and ld_start are ignored; data holds and data_valid=0.
- INIT behaviour: busy=1 and ld_ready=0. A counter writes boot image word i to address i for i = 0..DEPTH-1, then the FSM enters IDLE.
- Reset asserted mid-LOAD or mid-INIT aborts the operation immediately. Array contents already written are kept, but with the macro defined INIT rewrites the whole array.

## Timing
- Read latency is 1 cycle: a request at edge N gives data and data_valid at edge N+1.
- Back-to-back reads run at one per cycle.
- Load throughput is one word per cycle. ld_ready is combinational from state; there is no wait state between ld_start and the first word.
- ld_done asserts in the cycle after the ld_last edge. busy falls in that same cycle, so a read can be issued on that cycle.
- INIT takes exactly DEPTH cycles after reset_n rises; busy is low from edge DEPTH onward.

## Configuration
- Macro: PROG_MEM_BOOT_EN.
- Defined:
  - INIT state is present.
  - Boot image: word 0 = 16'hF8AA (LDI R0,$AA), word 1 = 16'h1080 (STS $80,R0), word 2 = 16'h1983 (LDS R1,$83), word 3 = 16'h1181 (STS $81,R1), word 4 = 16'hB800 (STOP). All other words are 0.
  - Words are zero-extended when DATA_W > 16. DATA_W < 16 is illegal and must trigger an elaboration error.
- Undefined:
  - No INIT state; reset goes straight to IDLE with busy=0.
  - Array contents are undefined (X in simulation) until loaded.

## Test plan
- Boot image (macro on, DEPTH=256): release reset and wait 256 cycles with busy=1 → busy=0. Reads at addresses 0..5 return F8AA, 1080, 1983, 1181, B800, 0000, each with data_valid one cycle after rd_en.
- Load and read-back (macro off): ld_start with ld_base=8'h10, then 3 words 1234/5678/9ABC with ld_last on the third → ld_done one cycle later and ld_count=3. Reads at 10, 11, 12 return those words.
- Wrap-around: ld_base=8'hFE, 4 words → addresses FE, FF, 00, 01 written and ld_overflow=0. A DEPTH=4 load of 5 words → ld_overflow=1 and address base+0 holds the 5th word.
- Simultaneous rd_en and ld_start in IDLE: the read data appears at the next edge and the FSM is in LOAD. rd_en during LOAD → data_valid stays 0 and data is unchanged.
- Reset mid-LOAD (macro off): assert reset_n=0 after 2 of 4 words → all outputs return to reset values asynchronously. Addresses already written keep their data, and the next ld_start works normally.

Source files
------------

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x DATA_W program memory for the DAPA2014 core.
// Registered-read fetch port plus a handshaked run-time load port.
// Optional boot image written after reset: define PROG_MEM_BOOT_EN.
module prog_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_word,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_overflow
);

    localparam int unsigned       CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(2**ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    // Elaboration-time parameter sanity
    if (DEPTH < 1 || DEPTH > 2**ADDR_W) begin : g_bad_depth
        $error("prog_mem: DEPTH must lie in 1..2**ADDR_W");
    end

`ifdef PROG_MEM_BOOT_EN
    if (DATA_W < 16) begin : g_bad_width
        $error("prog_mem: DATA_W below 16 cannot hold the boot image");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_INIT = 2'd2} state_t;
    localparam state_t RST_STATE = S_INIT;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEPTH - 1);

    // Boot program: LDI R0,$AA / STS $80,R0 / LDS R1,$83 / STS $81,R1 / STOP
    function automatic logic [DATA_W-1:0] boot_word(input logic [CNT_W-1:0] idx);
        logic [15:0] w;
        case (idx)
            CNT_W'(0): w = 16'hF8AA;
            CNT_W'(1): w = 16'h1080;
            CNT_W'(2): w = 16'h1983;
            CNT_W'(3): w = 16'h1181;
            CNT_W'(4): w = 16'hB800;
            default:   w = 16'h0000;
        endcase
        return DATA_W'(w);
    endfunction

    logic [CNT_W-1:0] init_cnt;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   base_mod;
    logic                rd_fire;
    logic                ld_go;
    logic                ld_acc;
    logic                rd_hit;
    logic [DATA_W-1:0]   rd_word;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    assign rd_fire  = (state == S_IDLE) && rd_en;
    assign ld_go    = (state == S_IDLE) && ld_start;
    assign ld_acc   = (state == S_LOAD) && ld_valid;
    assign base_mod = ADDR_W'({1'b0, ld_base} % DEPTH_V);
    assign rd_hit   = {1'b0, addr} < DEPTH_V;
    assign rd_word  = rd_hit ? mem[addr] : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ld_start) state_nxt = S_LOAD;
            S_LOAD: if (ld_valid && ld_last) state_nxt = S_IDLE;
`ifdef PROG_MEM_BOOT_EN
            S_INIT: if (init_cnt == INIT_LAST) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy     = 1'b0;
        ld_ready = 1'b0;
        case (state)
            S_LOAD: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
            end
`ifdef PROG_MEM_BOOT_EN
            S_INIT: busy = 1'b1;
`endif
            default: ;
        endcase
    end

    // Write port select: boot sequencer during INIT, loader otherwise
    always_comb begin
        mem_we = ld_acc;
        mem_wa = wr_ptr;
        mem_wd = ld_word;
`ifdef PROG_MEM_BOOT_EN
        if (state == S_INIT) begin
            mem_we = 1'b1;
            mem_wa = ADDR_W'(init_cnt);
            mem_wd = boot_word(init_cnt);
        end
`endif
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

`ifdef PROG_MEM_BOOT_EN
    // Boot image address counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= '0;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + CNT_W'(1);
        end
    end
`endif

    // Fetch port: one-cycle registered read, data held when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_fire;
            if (rd_fire) begin
                data <= rd_word;
            end
        end
    end

    // Loader bookkeeping: wrapping write pointer, saturating count, sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
            ld_done     <= 1'b0;
        end else begin
            ld_done <= ld_acc && ld_last;
            if (ld_go) begin
                wr_ptr      <= base_mod;
                ld_count    <= '0;
                ld_overflow <= 1'b0;
            end else if (ld_acc) begin
                wr_ptr <= (wr_ptr == LAST_A) ? '0 : wr_ptr + ADDR_W'(1);
                if (ld_count != CNT_MAX) begin
                    ld_count <= ld_count + CNT_W'(1);
                end
                if (ld_count >= DEPTH_V) begin
                    ld_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: a full-depth instance and a DEPTH=4 instance, random
// loads/reads checked through per-instance scoreboards against array models.
`timescale 1ns/1ps
module tb_prog_mem;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int D1 = 256;
    localparam int D2 = 4;
`ifdef PROG_MEM_BOOT_EN
    localparam bit BOOT = 1'b1;
`else
    localparam bit BOOT = 1'b0;
`endif
    localparam int EXP_INIT = BOOT ? D1 : 0;

    typedef struct {
        logic [DW-1:0] v;
        bit            known;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Full-depth instance
    logic          rd_en = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [AW-1:0] addr = '0, ld_base = '0;
    logic [DW-1:0] ld_word = '0;
    logic [DW-1:0] data;
    logic          data_valid, busy, ld_ready, ld_done, ld_overflow;
    logic [AW:0]   ld_count;

    // Shallow instance
    logic          rd_en_s = 1'b0, ld_start_s = 1'b0, ld_valid_s = 1'b0, ld_last_s = 1'b0;
    logic [AW-1:0] addr_s = '0, ld_base_s = '0;
    logic [DW-1:0] ld_word_s = '0;
    logic [DW-1:0] data_s;
    logic          data_valid_s, busy_s, ld_ready_s, ld_done_s, ld_overflow_s;
    logic [AW:0]   ld_count_s;

    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D1)) u_dut (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .addr(addr), .data(data),
        .data_valid(data_valid), .busy(busy), .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_word(ld_word), .ld_last(ld_last), .ld_ready(ld_ready),
        .ld_done(ld_done), .ld_count(ld_count), .ld_overflow(ld_overflow)
    );

    prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D2)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en_s), .addr(addr_s), .data(data_s),
        .data_valid(data_valid_s), .busy(busy_s), .ld_start(ld_start_s), .ld_base(ld_base_s),
        .ld_valid(ld_valid_s), .ld_word(ld_word_s), .ld_last(ld_last_s), .ld_ready(ld_ready_s),
        .ld_done(ld_done_s), .ld_count(ld_count_s), .ld_overflow(ld_overflow_s)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: memory contents, which words are defined, pending reads
    logic [DW-1:0] m1 [D1];
    bit            k1 [D1];
    int            kl1 [$];
    logic [DW-1:0] m2 [D2];
    bit            k2 [D2];
    exp_t          q1 [$];
    exp_t          q2 [$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;
    logic [DW-1:0] wq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] boot_val(input int i);
        case (i)
            0: return 16'hF8AA;
            1: return 16'h1080;
            2: return 16'h1983;
            3: return 16'h1181;
            4: return 16'hB800;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        q1.delete();
        q2.delete();
        last1 = '0;
        last2 = '0;
`ifdef PROG_MEM_BOOT_EN
        kl1.delete();
        for (int i = 0; i < D1; i++) begin
            m1[i] = boot_val(i);
            k1[i] = 1'b1;
            kl1.push_back(i);
        end
        for (int i = 0; i < D2; i++) begin
            m2[i] = boot_val(i);
            k2[i] = 1'b1;
        end
`endif
    endtask

    task automatic write1(input int a, input logic [DW-1:0] w);
        m1[a] = w;
        if (!k1[a]) begin
            k1[a] = 1'b1;
            kl1.push_back(a);
        end
    endtask

    task automatic push1(input int a);
        exp_t e;
        if (a >= D1) begin e.v = '0; e.known = 1'b1; end
        else begin e.v = m1[a]; e.known = k1[a]; end
        q1.push_back(e);
    endtask

    task automatic push2(input int a);
        exp_t e;
        if (a >= D2) begin e.v = '0; e.known = 1'b1; end
        else begin e.v = m2[a]; e.known = k2[a]; end
        q2.push_back(e);
    endtask

    // Monitor, full-depth instance
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (data_valid) begin
                if (q1.size() == 0) begin
                    chk("unexpected_valid", 32'(data_valid), 32'd0);
                end else begin
                    e = q1.pop_front();
                    if (e.known) begin
                        chk("read", 32'(data), 32'(e.v));
                        last1 = e.v;
                    end
                end
            end else begin
                chk("data_hold", 32'(data), 32'(last1));
            end
        end
    end

    // Monitor, shallow instance
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (data_valid_s) begin
                if (q2.size() == 0) begin
                    chk("s_unexpected_valid", 32'(data_valid_s), 32'd0);
                end else begin
                    e = q2.pop_front();
                    if (e.known) begin
                        chk("s_read", 32'(data_s), 32'(e.v));
                        last2 = e.v;
                    end
                end
            end else begin
                chk("s_data_hold", 32'(data_s), 32'(last2));
            end
        end
    end

    task automatic idle();
        rd_en    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_data",      32'(data),        32'd0);
        chk("rst_valid",     32'(data_valid),  32'd0);
        chk("rst_busy",      32'(busy),        32'(BOOT));
        chk("rst_ready",     32'(ld_ready),    32'd0);
        chk("rst_done",      32'(ld_done),     32'd0);
        chk("rst_count",     32'(ld_count),    32'd0);
        chk("rst_overflow",  32'(ld_overflow), 32'd0);
        chk("rst_s_data",    32'(data_s),      32'd0);
        chk("rst_s_busy",    32'(busy_s),      32'(BOOT));
    endtask

    task automatic wait_ready(input int exp_cycles);
        int n = 0;
        while ((busy || busy_s) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_cycles", 32'(n), 32'(exp_cycles));
    endtask

    task automatic rd1(input int a);
        rd_en = 1'b1;
        addr  = AW'(a);
        push1(a);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic rd2(input int a);
        rd_en_s = 1'b1;
        addr_s  = AW'(a);
        push2(a);
        @(negedge clk);
        rd_en_s = 1'b0;
    endtask

    task automatic rd_burst(input int n);
        for (int i = 0; i < n; i++) begin
            if (kl1.size() > 0 && $urandom_range(0, 3) != 0) begin
                int a = kl1[$urandom_range(0, kl1.size() - 1)];
                rd_en = 1'b1;
                addr  = AW'(a);
                push1(a);
            end else begin
                rd_en = 1'b0;
                addr  = AW'($urandom);
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    // Load n words at base; optional idle gaps, optional read on the ld_start cycle
    task automatic load1(input int base, input int n, input bit gaps, input bit with_rd);
        int i = 0;
        int a;
        int exp_cnt;
        ld_start = 1'b1;
        ld_base  = AW'(base);
        if (with_rd && kl1.size() > 0) begin
            a     = kl1[$urandom_range(0, kl1.size() - 1)];
            rd_en = 1'b1;
            addr  = AW'(a);
            push1(a);
        end
        @(negedge clk);
        ld_start = 1'b0;
        rd_en    = 1'b0;
        chk("load_ready",     32'(ld_ready),    32'd1);
        chk("load_busy",      32'(busy),        32'd1);
        chk("load_count_clr", 32'(ld_count),    32'd0);
        chk("load_ovf_clr",   32'(ld_overflow), 32'd0);
        while (i < n) begin
            ld_valid = !gaps || ($urandom_range(0, 3) != 0);
            ld_word  = (i < wq.size()) ? wq[i] : DW'($urandom);
            ld_last  = ld_valid && (i == n - 1);
            rd_en    = 1'($urandom_range(0, 1));
            addr     = AW'($urandom);
            ld_start = 1'($urandom_range(0, 1));
            if (ld_valid) begin
                write1((base + i) % D1, ld_word);
                i++;
            end
            @(negedge clk);
        end
        idle();
        exp_cnt = (n > 256) ? 256 : n;
        chk("ld_done",     32'(ld_done),     32'd1);
        chk("done_busy",   32'(busy),        32'd0);
        chk("done_ready",  32'(ld_ready),    32'd0);
        chk("ld_count",    32'(ld_count),    32'(exp_cnt));
        chk("ld_overflow", 32'(ld_overflow), 32'(n > D1));
        rd_en = 1'b1;
        addr  = AW'(base);
        push1(base);
        @(negedge clk);
        rd_en = 1'b0;
        chk("ld_done_pulse", 32'(ld_done), 32'd0);
        wq.delete();
    endtask

    task automatic load2(input int base, input int n);
        int a;
        ld_start_s = 1'b1;
        ld_base_s  = AW'(base);
        @(negedge clk);
        ld_start_s = 1'b0;
        chk("s_load_ready", 32'(ld_ready_s), 32'd1);
        for (int i = 0; i < n; i++) begin
            ld_valid_s = 1'b1;
            ld_word_s  = DW'($urandom);
            ld_last_s  = (i == n - 1);
            a          = ((base % D2) + i) % D2;
            m2[a]      = ld_word_s;
            k2[a]      = 1'b1;
            @(negedge clk);
        end
        ld_valid_s = 1'b0;
        ld_last_s  = 1'b0;
        chk("s_ld_done",     32'(ld_done_s),     32'd1);
        chk("s_ld_count",    32'(ld_count_s),    32'(n));
        chk("s_ld_overflow", 32'(ld_overflow_s), 32'(n > D2));
    endtask

    task automatic mid_load_reset();
        ld_start = 1'b1;
        ld_base  = 8'h40;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_word  = DW'($urandom);
            write1(8'h40 + i, ld_word);
            @(negedge clk);
        end
        ld_word = 16'hDEAD;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals();
        idle();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(EXP_INIT);
        rd1(8'h40);
        rd1(8'h41);
        if (k1[8'h42]) rd1(8'h42);
        load1(8'h42, 2, 1'b0, 1'b0);
        rd1(8'h42);
        rd1(8'h43);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(EXP_INIT);

`ifdef PROG_MEM_BOOT_EN
        for (int a = 0; a < 6; a++) rd1(a);
`endif

        wq = '{16'h1234, 16'h5678, 16'h9ABC};
        load1(8'h10, 3, 1'b0, 1'b0);
        rd1(8'h10);
        rd1(8'h11);
        rd1(8'h12);

        load1(8'hFE, 4, 1'b0, 1'b0);
        rd1(8'hFE);
        rd1(8'hFF);
        rd1(8'h00);
        rd1(8'h01);

        load1(8'h20, 5, 1'b1, 1'b1);
        load1(8'h80, 256, 1'b0, 1'b0);
        load1(8'h33, 258, 1'b1, 1'b0);
        rd_burst(16);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 1) == 0) rd_burst(int'($urandom_range(4, 12)));
            else load1(int'($urandom_range(0, 255)), int'($urandom_range(1, 12)), 1'b1,
                       1'($urandom_range(0, 1)));
        end

        mid_load_reset();

        load2(6, 5);
        for (int a = 0; a < D2; a++) rd2(a);
        rd2(4);
        rd2(200);
        load2(1, 4);
        rd2(1);
        rd2(0);

        repeat (3) @(negedge clk);
        chk("drain_q1", 32'(q1.size()), 32'd0);
        chk("drain_q2", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
